// File: rtl/spi_reg_target.sv
// SPI mode-0 register target (MCP23S17-style): opcode/address/data framing,
// hardware-address match, sequential access and a fabric-side register port.
module spi_reg_target #(
  parameter int         NUM_REGS    = 22,
  parameter logic [3:0] OPC_HI      = 4'b0100,
  parameter int         HAEN        = 1,
  parameter int         SEQ_EN      = 1,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_RST_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sclk_i,
  input  logic       csn_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [2:0] hw_addr_i,
  input  logic [7:0] usr_addr_i,
  input  logic       usr_we_i,
  input  logic [7:0] usr_wdata_i,
  output logic [7:0] usr_rdata_o,
  output logic       spi_wr_o,
  output logic [7:0] spi_wr_addr_o,
  output logic [7:0] spi_wr_data_o,
  output logic       busy_o
);

  localparam int         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] LAST_ADDR = 8'(NUM_REGS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OPCODE = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  // Synchronisers carry no reset: a reset mid-transfer must not fabricate a
  // csn edge, so the FSM only restarts on a genuine csn fall.
  logic [SYNC_STAGES:0]   sclk_sr;
  logic [SYNC_STAGES:0]   csn_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;

  always_ff @(posedge clk_i) begin
    sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], sclk_i};
    csn_sr  <= {csn_sr[SYNC_STAGES-1:0], csn_i};
    mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi_i};
  end

  logic sclk_cur, sclk_prev, csn_cur, csn_prev, mosi_cur;
  logic sclk_rise, sclk_fall, csn_rise, csn_fall;

  assign sclk_cur  = sclk_sr[SYNC_STAGES-1];
  assign sclk_prev = sclk_sr[SYNC_STAGES];
  assign csn_cur   = csn_sr[SYNC_STAGES-1];
  assign csn_prev  = csn_sr[SYNC_STAGES];
  assign mosi_cur  = mosi_sr[SYNC_STAGES-1];

  assign sclk_rise = sclk_cur & ~sclk_prev & ~csn_cur;
  assign sclk_fall = ~sclk_cur & sclk_prev & ~csn_cur;
  assign csn_rise  = csn_cur & ~csn_prev;
  assign csn_fall  = ~csn_cur & csn_prev;

  logic [7:0] regs [NUM_REGS];
  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] ptr;
  logic       rw;

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       ptr_in_range;
  logic [7:0] next_ptr;
  logic [7:0] rx_rd_data;
  logic [7:0] next_rd_data;
  logic       opc_match;
  logic       spi_commit;

  // NOTE: every signal below gets a value on every path through this block;
  // a missing assignment in any branch would infer a latch.
  always_comb begin
    rx_byte      = {rx_sr, mosi_cur};
    byte_done    = sclk_rise && (bit_cnt == 3'd7);
    ptr_in_range = (ptr <= LAST_ADDR);
    next_ptr     = ptr;
    if (SEQ_EN != 0) begin
      next_ptr = (ptr >= LAST_ADDR) ? 8'h00 : ptr + 8'd1;
    end
    rx_rd_data   = (rx_byte <= LAST_ADDR) ? regs[rx_byte[IDX_W-1:0]] : 8'h00;
    next_rd_data = (next_ptr <= LAST_ADDR) ? regs[next_ptr[IDX_W-1:0]] : 8'h00;
    opc_match    = (rx_byte[7:4] == OPC_HI) &&
                   ((HAEN == 0) || (rx_byte[3:1] == hw_addr_i));
    spi_commit   = (state == ST_WDATA) && byte_done && ptr_in_range;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values no matter how the statements below are ordered.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state         <= ST_IDLE;
      bit_cnt       <= 3'd0;
      rx_sr         <= 7'd0;
      tx_sr         <= 8'h00;
      ptr           <= 8'h00;
      rw            <= 1'b0;
      miso_o        <= 1'b0;
      miso_oe_o     <= 1'b0;
      spi_wr_o      <= 1'b0;
      spi_wr_addr_o <= 8'h00;
      spi_wr_data_o <= 8'h00;
      busy_o        <= 1'b0;
    end else begin
      spi_wr_o <= 1'b0;
      busy_o   <= ~csn_cur;
      if (csn_rise) begin
        // Any partially shifted byte is simply dropped here.
        state     <= ST_IDLE;
        bit_cnt   <= 3'd0;
        miso_o    <= 1'b0;
        miso_oe_o <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (csn_fall) begin
          bit_cnt <= 3'd0;
          state   <= ST_OPCODE;
        end
      end else begin
        if (sclk_rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          ST_OPCODE: begin
            if (byte_done) begin
              rw    <= rx_byte[0];
              state <= opc_match ? ST_ADDR : ST_IGNORE;
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              ptr <= rx_byte;
              if (rw) begin
                state     <= ST_RDATA;
                tx_sr     <= rx_rd_data;
                miso_oe_o <= 1'b1;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (byte_done) begin
              if (ptr_in_range) begin
                spi_wr_o      <= 1'b1;
                spi_wr_addr_o <= ptr;
                spi_wr_data_o <= rx_byte;
              end
              ptr <= next_ptr;
            end
          end
          ST_RDATA: begin
            if (sclk_fall) begin
              miso_o <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (byte_done) begin
              ptr   <= next_ptr;
              tx_sr <= next_rd_data;
            end
          end
          default: begin
            miso_oe_o <= 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: the register file is reset because its power-up contents are
  // architecturally visible, which keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      regs        <= '{default: REG_RST_VAL};
      usr_rdata_o <= 8'h00;
    end else begin
      usr_rdata_o <= (usr_addr_i <= LAST_ADDR) ? regs[usr_addr_i[IDX_W-1:0]] : 8'h00;
      if (usr_we_i && (usr_addr_i <= LAST_ADDR)) begin
        regs[usr_addr_i[IDX_W-1:0]] <= usr_wdata_i;
      end
      // Issued after the fabric write so the SPI byte wins an address clash.
      if (spi_commit) begin
        regs[ptr[IDX_W-1:0]] <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_target.sv
// Scoreboard bench for spi_reg_target: a default instance plus one with
// HAEN=0/SEQ_EN=0; directed SPI and fabric traffic against queued expectations.
module tb_spi_reg_target;

  localparam int H = 8;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rstn, sclk, csn_a, csn_b, mosi;
  logic [2:0] hw_addr;
  logic [7:0] usr_addr, usr_wdata;
  logic       usr_we;

  logic       miso_a, oe_a, wr_a, busy_a;
  logic [7:0] rdata_a, wr_addr_a, wr_data_a;
  logic       miso_b, oe_b, wr_b, busy_b;
  logic [7:0] rdata_b, wr_addr_b, wr_data_b;

  always #5 clk = ~clk;

  spi_reg_target dut (
    .clk_i(clk), .rstn_i(rstn), .sclk_i(sclk), .csn_i(csn_a), .mosi_i(mosi),
    .miso_o(miso_a), .miso_oe_o(oe_a), .hw_addr_i(hw_addr),
    .usr_addr_i(usr_addr), .usr_we_i(usr_we), .usr_wdata_i(usr_wdata),
    .usr_rdata_o(rdata_a), .spi_wr_o(wr_a), .spi_wr_addr_o(wr_addr_a),
    .spi_wr_data_o(wr_data_a), .busy_o(busy_a)
  );

  spi_reg_target #(.HAEN(0), .SEQ_EN(0)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .sclk_i(sclk), .csn_i(csn_b), .mosi_i(mosi),
    .miso_o(miso_b), .miso_oe_o(oe_b), .hw_addr_i(hw_addr),
    .usr_addr_i(usr_addr), .usr_we_i(usr_we), .usr_wdata_i(usr_wdata),
    .usr_rdata_o(rdata_b), .spi_wr_o(wr_b), .spi_wr_addr_o(wr_addr_b),
    .spi_wr_data_o(wr_data_b), .busy_o(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_wr_a_q[$];
  logic [15:0] exp_wr_b_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  exp_miso_q[$];

  logic       sel = 1'b0;
  logic       rd_req = 1'b0, rd_sel = 1'b0, rd_vld = 1'b0, rd_sel_q = 1'b0;
  logic       miso_cap_vld = 1'b0;
  logic [7:0] miso_cap = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output presented with no expectation queued", name);
  endtask

  // Write-strobe monitors
  always @(negedge clk) begin
    if (wr_a) begin
      if (exp_wr_a_q.size() == 0) pop_fail("wr_a_unexpected");
      else check("wr_a", 32'({wr_addr_a, wr_data_a}), 32'(exp_wr_a_q.pop_front()));
    end
    if (wr_b) begin
      if (exp_wr_b_q.size() == 0) pop_fail("wr_b_unexpected");
      else check("wr_b", 32'({wr_addr_b, wr_data_b}), 32'(exp_wr_b_q.pop_front()));
    end
  end

  // Fabric read pipeline and monitor
  always @(posedge clk) begin
    rd_vld   <= rd_req;
    rd_sel_q <= rd_sel;
  end

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_rd_q.size() == 0) pop_fail("usr_rdata_unexpected");
      else check("usr_rdata", 32'(rd_sel_q ? rdata_b : rdata_a), 32'(exp_rd_q.pop_front()));
    end
  end

  // MISO byte monitor
  always @(posedge clk) begin
    if (miso_cap_vld) begin
      if (exp_miso_q.size() == 0) pop_fail("miso_unexpected");
      else check("miso_byte", 32'(miso_cap), 32'(exp_miso_q.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic usr_read(input logic s, input logic [7:0] a, input logic [7:0] e);
    exp_rd_q.push_back(e);
    usr_addr = a;
    rd_sel   = s;
    rd_req   = 1'b1;
    @(negedge clk);
    rd_req   = 1'b0;
  endtask

  task automatic usr_write(input logic [7:0] a, input logic [7:0] d);
    usr_addr  = a;
    usr_wdata = d;
    usr_we    = 1'b1;
    @(negedge clk);
    usr_we    = 1'b0;
  endtask

  task automatic cs_low(input logic s);
    sel = s;
    if (s) csn_b = 1'b0;
    else   csn_a = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high();
    csn_a = 1'b1;
    csn_b = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  // Shifts nbits of tx MSB-first; checks miso_oe before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic oe_exp,
                          input logic is_read, input logic collide);
    logic [7:0] rx;
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (H) @(negedge clk);
      rx[i] = sel ? miso_b : miso_a;
      check("miso_oe", 32'(sel ? oe_b : oe_a), 32'(oe_exp));
      sclk = 1'b1;
      if (collide && i == 0) begin
        // Commit lands on the third posedge after the rise; fabric write joins it.
        repeat (2) @(negedge clk);
        usr_addr  = 8'h07;
        usr_wdata = 8'hC3;
        usr_we    = 1'b1;
        @(negedge clk);
        usr_we    = 1'b0;
        repeat (H - 3) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      sclk = 1'b0;
    end
    if (is_read) begin
      miso_cap     = rx;
      miso_cap_vld = 1'b1;
      @(negedge clk);
      miso_cap_vld = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    spi_bits(tx, 8, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; sclk = 1'b0; csn_a = 1'b1; csn_b = 1'b1; mosi = 1'b0;
    hw_addr = 3'b101; usr_addr = 8'h00; usr_wdata = 8'h00; usr_we = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_miso",      32'(miso_a),    32'h0);
    check("rst_miso_oe",   32'(oe_a),      32'h0);
    check("rst_spi_wr",    32'(wr_a),      32'h0);
    check("rst_wr_addr",   32'(wr_addr_a), 32'h0);
    check("rst_wr_data",   32'(wr_data_a), 32'h0);
    check("rst_usr_rdata", 32'(rdata_a),   32'h0);
    check("rst_busy",      32'(busy_a),    32'h0);

    rstn = 1'b1;
    repeat (4) @(negedge clk);
    for (int a = 0; a < 22; a++) usr_read(1'b0, 8'(a), 8'h00);
    usr_read(1'b0, 8'h16, 8'h00);
    usr_read(1'b0, 8'hFF, 8'h00);

    // Basic addressed write
    exp_wr_a_q.push_back(16'h03A5);
    cs_low(1'b0);
    check("busy_active", 32'(busy_a), 32'h1);
    spi_byte(8'h4A); spi_byte(8'h03); spi_byte(8'hA5);
    cs_high();
    check("busy_idle", 32'(busy_a), 32'h0);
    usr_read(1'b0, 8'h03, 8'hA5);

    // Sequential read across the top of the map
    usr_write(8'h14, 8'h11);
    usr_write(8'h15, 8'h22);
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(8'h22);
    exp_miso_q.push_back(8'h00);
    cs_low(1'b0);
    spi_byte(8'h4B); spi_byte(8'h14);
    for (int k = 0; k < 3; k++) spi_bits(8'h00, 8, 1'b1, 1'b1, 1'b0);
    cs_high();
    check("oe_after_read", 32'(oe_a), 32'h0);
    check("miso_after_read", 32'(miso_a), 32'h0);

    // Hardware-address mismatch ignored with HAEN=1, accepted with HAEN=0
    cs_low(1'b0);
    spi_byte(8'h40); spi_byte(8'h09); spi_byte(8'h55);
    cs_high();
    usr_read(1'b0, 8'h09, 8'h00);
    exp_wr_b_q.push_back(16'h0955);
    cs_low(1'b1);
    spi_byte(8'h40); spi_byte(8'h09); spi_byte(8'h55);
    cs_high();
    usr_read(1'b1, 8'h09, 8'h55);

    // Partial data byte is discarded, next transfer is clean
    cs_low(1'b0);
    spi_byte(8'h4A); spi_byte(8'h05);
    spi_bits(8'hFF, 5, 1'b0, 1'b0, 1'b0);
    cs_high();
    usr_read(1'b0, 8'h05, 8'h00);
    exp_wr_a_q.push_back(16'h056E);
    cs_low(1'b0);
    spi_byte(8'h4A); spi_byte(8'h05); spi_byte(8'h6E);
    cs_high();
    usr_read(1'b0, 8'h05, 8'h6E);

    // Write pointer wraps from the last register to 0
    exp_wr_a_q.push_back(16'h1577);
    exp_wr_a_q.push_back(16'h0088);
    cs_low(1'b0);
    spi_byte(8'h4A); spi_byte(8'h15); spi_byte(8'h77); spi_byte(8'h88);
    cs_high();
    usr_read(1'b0, 8'h15, 8'h77);
    usr_read(1'b0, 8'h00, 8'h88);

    // Out-of-range write dropped, pointer wraps to 0 for the next byte
    exp_wr_a_q.push_back(16'h005A);
    cs_low(1'b0);
    spi_byte(8'h4A); spi_byte(8'h16); spi_byte(8'h99); spi_byte(8'h5A);
    cs_high();
    usr_read(1'b0, 8'h00, 8'h5A);
    usr_read(1'b0, 8'h01, 8'h00);

    // Same-cycle SPI commit and fabric write to 0x07: SPI wins
    exp_wr_a_q.push_back(16'h073C);
    cs_low(1'b0);
    spi_byte(8'h4A); spi_byte(8'h07);
    spi_bits(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    cs_high();
    usr_read(1'b0, 8'h07, 8'h3C);
    usr_read(1'b1, 8'h07, 8'hC3);

    // SEQ_EN=0: pointer stays on 0x02
    exp_wr_b_q.push_back(16'h0211);
    exp_wr_b_q.push_back(16'h0222);
    exp_wr_b_q.push_back(16'h0233);
    cs_low(1'b1);
    spi_byte(8'h4A); spi_byte(8'h02);
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33);
    cs_high();
    usr_read(1'b1, 8'h02, 8'h33);
    usr_read(1'b1, 8'h03, 8'h00);

    repeat (4) @(negedge clk);
    check("wr_a_pending",  32'(exp_wr_a_q.size()), 32'h0);
    check("wr_b_pending",  32'(exp_wr_b_q.size()), 32'h0);
    check("rd_pending",    32'(exp_rd_q.size()),   32'h0);
    check("miso_pending",  32'(exp_miso_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
